// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module : mem_ctrl_pkg
// Brief  : Shared state encoding and latency constants for mem_access_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_RD   = 3'd2,
    MEM_WAIT = 3'd3,
    FILL     = 3'd4,
    WR_THRU  = 3'd5,
    RESP     = 3'd6
  } mac_state_e;

  // Cycles from the accepting edge until resp_valid is high
  localparam int LAT_HIT   = 2;
  localparam int LAT_MISS  = 5;
  localparam int LAT_WRITE = 2;

endpackage : mem_ctrl_pkg

`default_nettype wire

// File: rtl/mem_ctrl_stats.sv
// ============================================================================
// Module : mem_ctrl_stats
// Brief  : Three saturating event counters (hits, misses, writes).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_ctrl_stats #(
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_hit,
  input  logic                  inc_miss,
  input  logic                  inc_write,
  output logic [STAT_WIDTH-1:0] stat_hits,
  output logic [STAT_WIDTH-1:0] stat_misses,
  output logic [STAT_WIDTH-1:0] stat_writes
);

  localparam logic [STAT_WIDTH-1:0] C_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  logic [STAT_WIDTH-1:0] r_hits;
  logic [STAT_WIDTH-1:0] r_misses;
  logic [STAT_WIDTH-1:0] r_writes;

  // Counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hits   <= '0;
      r_misses <= '0;
      r_writes <= '0;
    end else begin
      if (inc_hit && (r_hits != '1))
        r_hits <= r_hits + C_ONE;
      if (inc_miss && (r_misses != '1))
        r_misses <= r_misses + C_ONE;
      if (inc_write && (r_writes != '1))
        r_writes <= r_writes + C_ONE;
    end
  end

  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
  assign stat_writes = r_writes;

endmodule : mem_ctrl_stats

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module : mem_access_ctrl
// Brief  : Load/store sequencer over cache + single-port sync RAM
//          (read-miss fill, write-through, write-allocate).
//          Optional: ACCESS_STATS_EN adds hit/miss/write counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
`ifdef ACCESS_STATS_EN
  ,
  parameter int STAT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_oe,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  cache_we,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef ACCESS_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_hits,
  output logic [STAT_WIDTH-1:0] stat_misses,
  output logic [STAT_WIDTH-1:0] stat_writes
`endif
);

  mac_state_e r_state;
  mac_state_e w_state_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_resp_rdata;

  logic r_req_ready, r_resp_valid;
  logic r_cache_oe, r_cache_we;
  logic r_ram_cs, r_ram_we, r_ram_oe;

  logic w_req_ready, w_resp_valid;
  logic w_cache_oe, w_cache_we;
  logic w_ram_cs, w_ram_we, w_ram_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  // Strobes are decoded from the next state and registered, so each one
  // is a clean flop output aligned with the state it belongs to.
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_cache_oe   = 1'b0;
    w_cache_we   = 1'b0;
    w_ram_cs     = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_oe     = 1'b0;

    case (r_state)
      IDLE: begin
        if (req_valid)
          w_state_next = req_we ? WR_THRU : LOOKUP;
      end
      LOOKUP: begin
        if (cache_hit)
          w_state_next = RESP;
        else
          w_state_next = MEM_RD;
      end
      MEM_RD:   w_state_next = MEM_WAIT;
      MEM_WAIT: w_state_next = FILL;
      FILL:     w_state_next = RESP;
      WR_THRU:  w_state_next = RESP;
      RESP:     w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase

    case (w_state_next)
      IDLE:     w_req_ready  = 1'b1;
      LOOKUP:   w_cache_oe   = 1'b1;
      MEM_RD,
      MEM_WAIT: begin
        w_ram_cs = 1'b1;
        w_ram_oe = 1'b1;
      end
      FILL:     w_cache_we   = 1'b1;
      WR_THRU: begin
        w_ram_cs   = 1'b1;
        w_ram_we   = 1'b1;
        w_cache_we = 1'b1;
      end
      RESP:     w_resp_valid = 1'b1;
      default:  w_req_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_cache_oe   <= 1'b0;
      r_cache_we   <= 1'b0;
      r_ram_cs     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_oe     <= 1'b0;
    end else begin
      r_req_ready  <= w_req_ready;
      r_resp_valid <= w_resp_valid;
      r_cache_oe   <= w_cache_oe;
      r_cache_we   <= w_cache_we;
      r_ram_cs     <= w_ram_cs;
      r_ram_we     <= w_ram_we;
      r_ram_oe     <= w_ram_oe;
    end
  end

  // r_data carries store data, then hit or RAM data, to whoever needs it next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_data       <= '0;
      r_resp_rdata <= '0;
    end else begin
      if ((r_state == IDLE) && req_valid) begin
        r_addr <= req_addr;
        r_data <= req_wdata;
      end
      if ((r_state == LOOKUP) && cache_hit)
        r_data <= cache_rdata;
      if (r_state == MEM_WAIT)
        r_data <= ram_rdata;
      if (w_state_next == RESP)
        r_resp_rdata <= (r_state == LOOKUP) ? cache_rdata : r_data;
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign cache_addr  = r_addr;
  assign cache_oe    = r_cache_oe;
  assign cache_we    = r_cache_we;
  assign cache_wdata = r_data;
  assign ram_addr    = r_addr;
  assign ram_cs      = r_ram_cs;
  assign ram_we      = r_ram_we;
  assign ram_oe      = r_ram_oe;
  assign ram_wdata   = r_data;

`ifdef ACCESS_STATS_EN
  logic w_inc_hit, w_inc_miss, w_inc_write;

  assign w_inc_hit   = (r_state == LOOKUP) && cache_hit;
  assign w_inc_miss  = (r_state == LOOKUP) && !cache_hit;
  assign w_inc_write = (r_state == WR_THRU);

  mem_ctrl_stats #(
    .STAT_WIDTH (STAT_WIDTH)
  ) u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_hit     (w_inc_hit),
    .inc_miss    (w_inc_miss),
    .inc_write   (w_inc_write),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
    .stat_writes (stat_writes)
  );
`endif

endmodule : mem_access_ctrl

`default_nettype wire
